l2c_l1_inv_arb: RTL and testbench

Arbitrates L1 line-invalidation requests from two L2C agents onto one L1 invalidation port. Requester 0 is the L2C write path (MNI-write invalidations); requester 1 is the L2C fill/eviction path. One instance sits in front of the iL1 port and one in front of the dL1 port. Each line invalidation is two 32-byte halves, high half first, with one ack per half; a granted requester keeps the grant until both halves are acked.

---
 rtl/l2c_l1_inv_arb.sv | 122 ++++++++++++
 tb/tb_l2c_l1_inv_arb.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2c_l1_inv_arb.sv
// Two-requester round-robin arbiter for L1 line invalidations. Each line is
// sent as two 32-byte halves (high first) and the grant is held across both.
module l2c_l1_inv_arb #(
  parameter int TIMEOUT = 1023
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        i_req0,
  input  logic [31:0] i_adr0,
  output logic        o_ack0,
  input  logic        i_req1,
  input  logic [31:0] i_adr1,
  output logic        o_ack1,
  output logic        o_l1_inv_req,
  output logic [31:0] o_l1_inv_adr,
  input  logic        i_l1_inv_ack,
  output logic        o_busy,
  output logic        o_timeout
);

  localparam logic [9:0] TMO = 10'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP
  } state_t;

  state_t      state_q, state_d;
  logic        prio_q, prio_d;
  logic        gnt_q, gnt_d;
  logic        half_q, half_d;
  logic        timeout_q, timeout_d;
  logic [9:0]  wdog_q, wdog_d;
  logic [31:0] adr_q, adr_d;

  logic        idle_pick;
  logic        gnt_req;
  logic [31:0] gnt_adr;
  logic        issue_ack;

  // Contention resolves to the round-robin pointer; otherwise the lone requester.
  assign idle_pick = (i_req0 & i_req1) ? prio_q : i_req1;
  assign gnt_req   = gnt_q ? i_req1 : i_req0;
  assign gnt_adr   = gnt_q ? i_adr1 : i_adr0;
  assign issue_ack = (state_q == ST_ISSUE) & i_l1_inv_ack;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    gnt_d   = gnt_q;
    half_d  = half_q;
    wdog_d  = wdog_q;
    adr_d   = adr_q;
    case (state_q)
      ST_IDLE: begin
        if (i_req0 | i_req1) begin
          gnt_d   = idle_pick;
          adr_d   = idle_pick ? i_adr1 : i_adr0;
          half_d  = 1'b0;
          wdog_d  = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (i_l1_inv_ack) begin
          if (!half_q) begin
            half_d  = 1'b1;
            state_d = ST_GAP;
          end else begin
            half_d  = 1'b0;
            prio_d  = ~gnt_q;
            state_d = ST_IDLE;
          end
        end else if (wdog_q < TMO) begin
          wdog_d = wdog_q + 10'd1;
        end
      end
      ST_GAP: begin
        // A requester that drops out here abandons the line without moving prio.
        if (gnt_req) begin
          adr_d   = gnt_adr;
          wdog_d  = '0;
          state_d = ST_ISSUE;
        end else begin
          half_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    timeout_d = timeout_q | (wdog_d == TMO);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      prio_q    <= 1'b0;
      gnt_q     <= 1'b0;
      half_q    <= 1'b0;
      wdog_q    <= '0;
      adr_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      gnt_q     <= gnt_d;
      half_q    <= half_d;
      wdog_q    <= wdog_d;
      adr_q     <= adr_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_l1_inv_req = (state_q == ST_ISSUE);
  assign o_l1_inv_adr = adr_q;
  assign o_ack0       = issue_ack & ~gnt_q;
  assign o_ack1       = issue_ack & gnt_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_l2c_l1_inv_arb.sv
// Bench for l2c_l1_inv_arb: directed scenarios plus randomized protocol-following
// requesters, all checked every cycle against a line-level model.
module tb_l2c_l1_inv_arb;

  localparam int TMO = 8;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        i_req0 = 1'b0, i_req1 = 1'b0;
  logic [31:0] i_adr0 = '0, i_adr1 = '0;
  logic        o_ack0, o_ack1;
  logic        o_l1_inv_req;
  logic [31:0] o_l1_inv_adr;
  logic        i_l1_inv_ack = 1'b0;
  logic        o_busy, o_timeout;

  always #5 Clk = ~Clk;

  l2c_l1_inv_arb #(.TIMEOUT(TMO)) dut (
    .Clk(Clk), .Reset(Reset),
    .i_req0(i_req0), .i_adr0(i_adr0), .o_ack0(o_ack0),
    .i_req1(i_req1), .i_adr1(i_adr1), .o_ack1(o_ack1),
    .o_l1_inv_req(o_l1_inv_req), .o_l1_inv_adr(o_l1_inv_adr),
    .i_l1_inv_ack(i_l1_inv_ack), .o_busy(o_busy), .o_timeout(o_timeout)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Line-level model: who owns the port, how many halves are done, waiting for low half.
  int          m_owner;
  bit          m_gap;
  int          m_halves;
  int          m_rr;
  int          m_stall;
  bit          m_tmo;
  logic [31:0] m_adr;

  // Requester agents and L1 ack driver
  bit          ag_active[2];
  bit          ag_half[2];
  logic [31:0] ag_base[2];
  int          ag_left[2];
  int          ag_wait[2];
  bit          ag_malformed[2];
  int          ag_maxwait = 0;
  int          malformed_pct = 0;
  bit          rand_drop = 0;
  int          ack_mode = 0;
  bit          seen_ack[2];
  int          ack_log[$];

  logic        obs_req, obs_ack0, obs_ack1, obs_busy, obs_tmo;
  logic [31:0] obs_adr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_owner = -1; m_gap = 0; m_halves = 0; m_rr = 0; m_stall = 0; m_tmo = 0; m_adr = '0;
  endtask

  task automatic compare();
    logic e_req;
    e_req = (m_owner >= 0) && !m_gap;
    chk("l1_inv_req", 32'(o_l1_inv_req), 32'(e_req));
    chk("l1_inv_adr", o_l1_inv_adr, m_adr);
    chk("ack0", 32'(o_ack0), 32'(e_req && i_l1_inv_ack && m_owner == 0));
    chk("ack1", 32'(o_ack1), 32'(e_req && i_l1_inv_ack && m_owner == 1));
    chk("busy", 32'(o_busy), 32'(m_owner >= 0));
    chk("timeout", 32'(o_timeout), 32'(m_tmo));
  endtask

  task automatic model_step();
    bit rq;
    if (!Reset) begin
      model_reset();
    end else if (m_owner < 0) begin
      if (i_req0 || i_req1) begin
        m_owner  = (i_req0 && i_req1) ? m_rr : (i_req0 ? 0 : 1);
        m_adr    = (m_owner == 0) ? i_adr0 : i_adr1;
        m_halves = 0; m_gap = 0; m_stall = 0;
      end
    end else if (m_gap) begin
      rq = (m_owner == 0) ? i_req0 : i_req1;
      if (rq) begin
        m_adr = (m_owner == 0) ? i_adr0 : i_adr1;
        m_gap = 0; m_stall = 0;
      end else begin
        m_owner = -1;
      end
    end else if (i_l1_inv_ack) begin
      m_halves++;
      if (m_halves == 1) m_gap = 1;
      else begin
        m_rr = 1 - m_owner;
        m_owner = -1;
      end
    end else begin
      if (m_stall < TMO) m_stall++;
      if (m_stall == TMO) m_tmo = 1;
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic tick();
    #1;
    compare();
    obs_req = o_l1_inv_req; obs_adr = o_l1_inv_adr; obs_ack0 = o_ack0;
    obs_ack1 = o_ack1; obs_busy = o_busy; obs_tmo = o_timeout;
    seen_ack[0] = o_ack0; seen_ack[1] = o_ack1;
    if (o_ack0) ack_log.push_back(0);
    if (o_ack1) ack_log.push_back(1);
    model_step();
    @(negedge Clk);
  endtask

  task automatic agents_drive();
    for (int r = 0; r < 2; r++) begin
      if (ag_active[r] && seen_ack[r]) begin
        if (!ag_half[r] && !ag_malformed[r]) ag_half[r] = 1;
        else begin
          ag_active[r] = 0; ag_malformed[r] = 0;
          ag_wait[r] = (ag_maxwait > 0) ? int'($urandom_range(ag_maxwait, 0)) : 0;
        end
      end else if (!ag_active[r]) begin
        if (ag_wait[r] > 0) ag_wait[r]--;
        else if (ag_left[r] > 0) begin
          ag_active[r] = 1; ag_half[r] = 0; ag_left[r]--;
          ag_base[r] = $urandom() & 32'hFFFF_FFC0;
          ag_malformed[r] = (int'($urandom_range(99, 0)) < malformed_pct);
        end
      end else if (rand_drop && !ag_half[r] && m_owner != r && $urandom_range(15, 0) == 0) begin
        ag_active[r] = 0; ag_left[r]++;
      end
    end
    i_req0 = ag_active[0];
    i_adr0 = ag_base[0] | (ag_half[0] ? 32'h0 : 32'h20);
    i_req1 = ag_active[1];
    i_adr1 = ag_base[1] | (ag_half[1] ? 32'h0 : 32'h20);
    case (ack_mode)
      0:       i_l1_inv_ack = 1'b0;
      1:       i_l1_inv_ack = 1'b1;
      default: i_l1_inv_ack = ($urandom_range(9, 0) < 6);
    endcase
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      agents_drive();
      tick();
    end
  endtask

  task automatic clear_agents();
    for (int r = 0; r < 2; r++) begin
      ag_active[r] = 0; ag_half[r] = 0; ag_left[r] = 0; ag_wait[r] = 0;
      ag_malformed[r] = 0; seen_ack[r] = 0; ag_base[r] = '0;
    end
    i_req0 = 0; i_req1 = 0; i_adr0 = '0; i_adr1 = '0;
  endtask

  task automatic do_reset();
    Reset = 0; i_l1_inv_ack = 0; ack_mode = 0; ag_maxwait = 0;
    malformed_pct = 0; rand_drop = 0;
    clear_agents();
    tick();
    tick();
    Reset = 1;
    ack_log.delete();
  endtask

  task automatic check_log(input string name, input int exp[$]);
    chk({name, "_len"}, 32'(ack_log.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < ack_log.size(); i++)
      chk(name, 32'(ack_log[i]), 32'(exp[i]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int e[$];
    model_reset();
    clear_agents();
    repeat (2) @(posedge Clk);
    @(negedge Clk);

    // Reset state and the basic single-line flow
    do_reset();
    chk("rst_busy", 32'(obs_busy), 32'd0);
    chk("rst_req", 32'(obs_req), 32'd0);
    chk("rst_tmo", 32'(obs_tmo), 32'd0);
    i_req0 = 1; i_adr0 = 32'h8000_1060;
    tick();
    chk("t1_idle_req", 32'(obs_req), 32'd0);
    i_l1_inv_ack = 1;
    tick();
    chk("t1_issue_req", 32'(obs_req), 32'd1);
    chk("t1_issue_adr", obs_adr, 32'h8000_1060);
    chk("t1_ack0", 32'(obs_ack0), 32'd1);
    chk("t1_ack1", 32'(obs_ack1), 32'd0);
    i_l1_inv_ack = 0; i_adr0 = 32'h8000_1040;
    tick();
    chk("t1_gap_req", 32'(obs_req), 32'd0);
    chk("t1_gap_busy", 32'(obs_busy), 32'd1);
    i_l1_inv_ack = 1;
    tick();
    chk("t1_low_adr", obs_adr, 32'h8000_1040);
    chk("t1_low_ack0", 32'(obs_ack0), 32'd1);
    i_l1_inv_ack = 0; i_req0 = 0;
    tick();
    chk("t1_done_busy", 32'(obs_busy), 32'd0);
    $display("test single_line done");

    // Simultaneous requests after reset: requester 0 first
    do_reset();
    ack_mode = 1; ag_left[0] = 1; ag_left[1] = 1;
    run(14);
    e = '{0, 0, 1, 1};
    check_log("t2_order", e);
    $display("test simultaneous done");

    // Back-to-back contention alternates grants
    do_reset();
    ack_mode = 1; ag_left[0] = 3; ag_left[1] = 3;
    run(30);
    e = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1};
    check_log("t3_alternate", e);
    $display("test alternate done");

    // Requester abandons after first half; prio must stay on requester 0
    do_reset();
    ack_mode = 1; malformed_pct = 100; ag_left[0] = 1;
    run(8);
    malformed_pct = 0; ag_left[0] = 1; ag_left[1] = 1;
    run(14);
    e = '{0, 0, 0, 1, 1};
    check_log("t4_abandon", e);
    $display("test abandon done");

    // Watchdog: no acks for TMO issue cycles, then completion still works
    do_reset();
    ack_mode = 0; ag_left[0] = 1;
    run(1);
    for (int i = 1; i <= TMO; i++) begin
      run(1);
      chk("t5_stall_req", 32'(obs_req), 32'd1);
      chk("t5_stall_tmo", 32'(obs_tmo), 32'd0);
    end
    run(1);
    chk("t5_tmo_set", 32'(obs_tmo), 32'd1);
    ack_mode = 1;
    run(10);
    chk("t5_tmo_sticky", 32'(obs_tmo), 32'd1);
    e = '{0, 0};
    check_log("t5_complete", e);
    $display("test watchdog done");

    // Reset during the second half's issue
    do_reset();
    ack_mode = 1; ag_left[0] = 1;
    run(8);
    ack_log.delete();
    ag_left[0] = 1;
    run(2);
    ack_mode = 0;
    run(2);
    chk("t6_issue2_req", 32'(obs_req), 32'd1);
    Reset = 0;
    run(1);
    Reset = 1;
    clear_agents();
    i_l1_inv_ack = 1;
    tick();
    chk("t6_post_req", 32'(obs_req), 32'd0);
    chk("t6_post_busy", 32'(obs_busy), 32'd0);
    chk("t6_post_ack0", 32'(obs_ack0), 32'd0);
    ack_log.delete();
    ack_mode = 1; ag_left[0] = 1; ag_left[1] = 1;
    run(14);
    e = '{0, 0, 1, 1};
    check_log("t6_prio_reset", e);
    $display("test mid_reset done");

    // Randomized traffic against the model
    do_reset();
    ag_maxwait = 3; malformed_pct = 10; rand_drop = 1; ack_mode = 2;
    ag_left[0] = 60; ag_left[1] = 60;
    run(1500);
    $display("test random done: %0d acks observed", ack_log.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
